// File: rtl/sine_rom_sched.sv
// Round-robin scheduler that time-shares one quarter-wave sine ROM among NUM_CH phase accumulators.
// Optional build macro SINE_SCHED_PRIO_EN: channel 0, when enabled, wins every grant.
module sine_rom_sched #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PHASE_W = 5,
  parameter int unsigned STEP_W  = 3,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*STEP_W-1:0] step,
  output logic [2:0]               rom_addr,
  input  logic [3:0]               rom_data,
  output logic [3:0]               sample,
  output logic [CH_W-1:0]          sample_ch,
  output logic                     sample_valid,
  input  logic                     sample_ready
);

  typedef enum logic [1:0] {IDLE, LOOKUP, PRESENT} state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase [NUM_CH];
  logic [CH_W-1:0]    rr_ptr;
  logic [CH_W-1:0]    grant;

  logic               accept_c;
  logic [CH_W-1:0]    next_ptr_c;
  logic [CH_W-1:0]    base_c;
  logic [CH_W-1:0]    pick_c;
  logic               found_c;
  int unsigned        idx_c;
  logic [PHASE_W-1:0] nphase_c [NUM_CH];

  // Mirror the quarter-wave address on the second and fourth quadrants
  function automatic logic [2:0] fold(input logic [PHASE_W-1:0] p);
    return p[2:0] ^ {3{p[3]}};
  endfunction

  assign accept_c   = (state == PRESENT) && sample_ready;
  assign next_ptr_c = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
  assign base_c     = accept_c ? next_ptr_c : rr_ptr;

  // Cyclic search for the first enabled channel starting at the pointer in effect this cycle
  always_comb begin
    found_c = 1'b0;
    pick_c  = '0;
    idx_c   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx_c = 32'(base_c) + k;
      if (idx_c >= NUM_CH) idx_c = idx_c - NUM_CH;
      if (!found_c && ch_en[idx_c[CH_W-1:0]]) begin
        found_c = 1'b1;
        pick_c  = idx_c[CH_W-1:0];
      end
    end
`ifdef SINE_SCHED_PRIO_EN
    if (ch_en[0]) begin
      found_c = 1'b1;
      pick_c  = '0;
    end
`else
`endif
  end

  // Phase seen after this edge; the new grant's address must use it when a channel re-grants itself
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      nphase_c[i] = phase[i];
      if (accept_c && grant == CH_W'(i))
        nphase_c[i] = phase[i] + PHASE_W'(step[i*STEP_W +: STEP_W]);
      if (!ch_en[i])
        nphase_c[i] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      for (int unsigned i = 0; i < NUM_CH; i++) phase[i] <= '0;
      rr_ptr       <= '0;
      grant        <= '0;
      rom_addr     <= '0;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) phase[i] <= nphase_c[i];
      case (state)
        IDLE: begin
          if (found_c) begin
            grant    <= pick_c;
            rom_addr <= fold(nphase_c[pick_c]);
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          sample       <= rom_data ^ {4{phase[grant][PHASE_W-1]}};
          sample_ch    <= grant;
          sample_valid <= 1'b1;
          state        <= PRESENT;
        end
        PRESENT: begin
          if (sample_ready) begin
            rr_ptr       <= next_ptr_c;
            sample_valid <= 1'b0;
            if (found_c) begin
              grant    <= pick_c;
              rom_addr <= fold(nphase_c[pick_c]);
              state    <= LOOKUP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
